// File: rtl/div_radix2_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the Execute stage.
// Resolves one quotient bit per cycle, stalls the pipeline while busy and holds its result until E advances.
module div_radix2_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             startE,
    input  logic             signedE,
    input  logic [WIDTH-1:0] src_aE,
    input  logic [WIDTH-1:0] src_bE,
    input  logic             cancel,
    input  logic             hold,
    output logic             div_stall,
    output logic             div_valid,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);

    localparam int CNTW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state_q;
    logic [CNTW-1:0]   cnt_q;
    logic [WIDTH-1:0]  dvd_q;
    logic [WIDTH-1:0]  dvs_q;
    logic [WIDTH-1:0]  prem_q;
    logic [WIDTH-1:0]  quo_q;
    logic [WIDTH-1:0]  rem_q;
    logic              qneg_q;
    logic              rneg_q;
    logic              valid_q;

    logic [WIDTH-1:0]  absA;
    logic [WIDTH-1:0]  absB;
    logic [WIDTH:0]    shifted;
    logic [WIDTH:0]    diff;
    logic              qbit;
    logic [WIDTH-1:0]  prem_d;
    logic [WIDTH-1:0]  dvd_d;
    logic              lastStep;

    // The dividend register doubles as the quotient accumulator: each step shifts out one
    // dividend bit into the partial remainder and shifts the new quotient bit in at the bottom.
    always_comb begin
        absA     = (signedE && src_aE[WIDTH-1]) ? -src_aE : src_aE;
        absB     = (signedE && src_bE[WIDTH-1]) ? -src_bE : src_bE;
        shifted  = {prem_q, dvd_q[WIDTH-1]};
        diff     = shifted - {1'b0, dvs_q};
        qbit     = ~diff[WIDTH];
        prem_d   = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        dvd_d    = {dvd_q[WIDTH-2:0], qbit};
        lastStep = (cnt_q == CNTW'(WIDTH - 1));
    end

    assign div_stall = (((state_q == IDLE) && startE) || (state_q == BUSY)) && !cancel;
    assign div_valid = valid_q;
    assign quo       = quo_q;
    assign rem       = rem_q;

    // A flush overrides everything; quo/rem are left as-is because valid gates them.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (cancel) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (startE) begin
                        state_q <= BUSY;
                        cnt_q   <= '0;
                        dvd_q   <= absA;
                        dvs_q   <= absB;
                        prem_q  <= '0;
                        qneg_q  <= (src_aE[WIDTH-1] ^ src_bE[WIDTH-1]) & signedE;
                        rneg_q  <= src_aE[WIDTH-1] & signedE;
                    end
                end
                BUSY: begin
                    dvd_q  <= dvd_d;
                    prem_q <= prem_d;
                    cnt_q  <= cnt_q + CNTW'(1);
                    if (lastStep) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        quo_q   <= qneg_q ? -dvd_d : dvd_d;
                        rem_q   <= rneg_q ? -prem_d : prem_d;
                    end
                end
                DONE: begin
                    // startE is still high here for the same instruction, so never restart.
                    if (!hold) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_radix2_iter.sv
// Scoreboard bench for div_radix2_iter: directed divides push expected {quo,rem};
// a monitor pops and compares whenever a new result appears on div_valid.
module tb_div_radix2_iter;

    localparam int WIDTH   = 32;
    localparam int LATENCY = WIDTH + 1;

    logic             clk;
    logic             resetn;
    logic             startE;
    logic             signedE;
    logic [WIDTH-1:0] src_aE;
    logic [WIDTH-1:0] src_bE;
    logic             cancel;
    logic             hold;
    logic             div_stall;
    logic             div_valid;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    int checks = 0;
    int fails  = 0;
    logic [2*WIDTH-1:0] sb[$];
    logic prevValid = 1'b0;

    div_radix2_iter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .startE    (startE),
        .signedE   (signedE),
        .src_aE    (src_aE),
        .src_bE    (src_bE),
        .cancel    (cancel),
        .hold      (hold),
        .div_stall (div_stall),
        .div_valid (div_valid),
        .quo       (quo),
        .rem       (rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: one pop per new result, sampled just after the clock edge.
    always @(posedge clk) begin
        #1;
        if (div_valid && !prevValid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected result", 32'h1, 32'h0);
            end else begin
                logic [2*WIDTH-1:0] e;
                e = sb.pop_front();
                checkOutput("quo", quo, e[2*WIDTH-1:WIDTH]);
                checkOutput("rem", rem, e[WIDTH-1:0]);
            end
        end
        prevValid = div_valid;
    end

    // Caller is positioned at a negedge; inputs are driven immediately.
    task automatic applyStimulus(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] expQ, input logic [WIDTH-1:0] expR,
                                 input int holdCycles);
        int cycles;
        int stallCnt;
        startE  = 1'b1;
        signedE = s;
        src_aE  = a;
        src_bE  = b;
        sb.push_back({expQ, expR});
        cycles   = 0;
        stallCnt = 0;
        #1;
        while (!div_valid && cycles < 100) begin
            if (div_stall) stallCnt++;
            @(negedge clk);
            cycles++;
        end
        checkOutput("latency", cycles, LATENCY);
        checkOutput("stall cycles", stallCnt, LATENCY);
        checkOutput("stall in DONE", {31'b0, div_stall}, 32'h0);
        hold = (holdCycles > 0);
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            checkOutput("held valid", {31'b0, div_valid}, 32'h1);
            checkOutput("held quo", quo, expQ);
            checkOutput("held rem", rem, expR);
            checkOutput("held stall", {31'b0, div_stall}, 32'h0);
        end
        hold = 1'b0;
        @(negedge clk);
        startE = 1'b0;
        #1;
        checkOutput("valid after advance", {31'b0, div_valid}, 32'h0);
        checkOutput("idle stall", {31'b0, div_stall}, 32'h0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        resetn  = 1'b0;
        startE  = 1'b0;
        signedE = 1'b0;
        src_aE  = '0;
        src_bE  = '0;
        cancel  = 1'b0;
        hold    = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset stall", {31'b0, div_stall}, 32'h0);
        checkOutput("reset valid", {31'b0, div_valid}, 32'h0);
        checkOutput("reset quo", quo, 32'h0);
        checkOutput("reset rem", rem, 32'h0);
        resetn = 1'b1;
        @(negedge clk);

        $display("[TB] basic unsigned and signed divides");
        applyStimulus(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
        applyStimulus(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0);
        applyStimulus(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 0);
        applyStimulus(1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 0);

        $display("[TB] overflow and divide by zero");
        applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 0);
        applyStimulus(1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 0);
        applyStimulus(1'b1, 32'hFFFFFFFB, 32'd0, 32'd1, 32'hFFFFFFFB, 0);

        $display("[TB] cancel mid-divide then restart");
        startE  = 1'b1;
        signedE = 1'b0;
        src_aE  = 32'd100;
        src_bE  = 32'd7;
        repeat (10) @(negedge clk);
        cancel = 1'b1;
        #1;
        checkOutput("stall under cancel", {31'b0, div_stall}, 32'h0);
        checkOutput("valid under cancel", {31'b0, div_valid}, 32'h0);
        @(negedge clk);
        cancel = 1'b0;
        applyStimulus(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0);

        $display("[TB] hold in DONE");
        applyStimulus(1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 5);

        $display("[TB] reset during busy");
        startE  = 1'b1;
        signedE = 1'b0;
        src_aE  = 32'd100;
        src_bE  = 32'd7;
        repeat (6) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        startE = 1'b0;
        #1;
        checkOutput("mid reset stall", {31'b0, div_stall}, 32'h0);
        checkOutput("mid reset valid", {31'b0, div_valid}, 32'h0);
        checkOutput("mid reset quo", quo, 32'h0);
        checkOutput("mid reset rem", rem, 32'h0);
        resetn = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", sb.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
